// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg
// Shared definitions for the DLX control path.
//   dlx_state_t   : the seven sequencer states.
//   STG_*         : bit index of each stage enable inside a stage vector; the
//                   datapath uses the same indices to pick its enables.
//   stage_onehot  : maps a sequencer state to its one-hot stage vector
//                   (all zero for S_HALT and S_ERR).
// -----------------------------------------------------------------------------
package dlx_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } dlx_state_t;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input dlx_state_t s);
        logic [NUM_STAGES-1:0] v;
        v = '0;
        case (s)
            S_IF:    v[STG_IF]  = 1'b1;
            S_ID:    v[STG_ID]  = 1'b1;
            S_EX:    v[STG_EX]  = 1'b1;
            S_MEM:   v[STG_MEM] = 1'b1;
            S_WB:    v[STG_WB]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dlx_wait_timer.sv
// -----------------------------------------------------------------------------
// dlx_wait_timer
// Counts consecutive wait cycles of the sequencer and flags the last allowed
// one. The count sits at zero whenever clr is high; it advances once per cycle
// while run is high.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (wins over run)
//   run        : this cycle is a wait cycle (waiting state, valid still low)
//   expired    : this wait cycle is number TIMEOUT; without valid the
//                sequencer must give up
// -----------------------------------------------------------------------------
module dlx_wait_timer #(
    parameter int TMO_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    // Count value seen during the TIMEOUT-th wait cycle.
    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == LAST);

endmodule

// File: rtl/dlx_ctrl_seq.sv
// -----------------------------------------------------------------------------
// dlx_ctrl_seq
// Multi-cycle control sequencer of the DLX core. Steps each instruction
// through IF -> ID -> EX -> [MEM] -> [WB], skipping MEM/WB according to the
// decoder flags captured in ID, waits on the memory valids with a timeout,
// honours a halt request at retirement and counts retired instructions.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   i_data_valid          : instruction ROM data valid (looked at only in S_IF)
//   d_data_valid          : data RAM access complete (looked at only in S_MEM)
//   is_mem, is_wb         : decoder class flags, captured in S_ID
//   halt_req              : stop after the current instruction retires
//   IF, ID, EX, MEM, WB   : one-hot stage enables, all 0 in S_HALT / S_ERR
//   retire                : pulse in the last cycle of an instruction
//   retire_cnt            : retired-instruction count, wraps modulo 2^CNT_W
//   halted, timeout_err   : high in S_HALT / S_ERR respectively
//   state_dbg             : current sequencer state, for observation only
//
// Handshake: the valids are level inputs with no ready back-channel. A waiting
// state completes in the first cycle its valid is seen high; a valid high in
// any other state has no effect.
// -----------------------------------------------------------------------------
module dlx_ctrl_seq
    import dlx_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TMO_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_data_valid,
    input  logic             d_data_valid,
    input  logic             is_mem,
    input  logic             is_wb,
    input  logic             halt_req,
    output logic             IF,
    output logic             ID,
    output logic             EX,
    output logic             MEM,
    output logic             WB,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted,
    output logic             timeout_err,
    output dlx_state_t       state_dbg
);

    dlx_state_t             state, state_nxt;
    logic                   mem_l, wb_l;
    logic                   wait_run, wait_clr, wait_expired;
    logic [NUM_STAGES-1:0]  stage;

    // A wait cycle is a cycle in a waiting state whose valid is still low.
    // Every other cycle holds the timer at zero, so it starts from zero on
    // every entry into S_IF or S_MEM.
    assign wait_run = ((state == S_IF)  && !i_data_valid) ||
                      ((state == S_MEM) && !d_data_valid);
    assign wait_clr = !wait_run;

    dlx_wait_timer #(
        .TMO_W   (TMO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (wait_clr),
        .run     (wait_run),
        .expired (wait_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction class flags, captured once per instruction in ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_l <= 1'b0;
            wb_l  <= 1'b0;
        end else if (state == S_ID) begin
            mem_l <= is_mem;
            wb_l  <= is_wb;
        end
    end

    // Retired-instruction counter; natural wrap of the adder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Next state and retire pulse. The retire decision depends on the flags
    // and, in S_MEM, on d_data_valid, so retire is combinational on inputs.
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_IF: begin
                if (i_data_valid) begin
                    state_nxt = S_ID;
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_ID: begin
                state_nxt = S_EX;
            end
            S_EX: begin
                if (mem_l) begin
                    state_nxt = S_MEM;
                end else if (wb_l) begin
                    state_nxt = S_WB;
                end else begin
                    retire    = 1'b1;
                    state_nxt = halt_req ? S_HALT : S_IF;
                end
            end
            S_MEM: begin
                // Valid in the expiring cycle still completes the access.
                if (d_data_valid) begin
                    if (wb_l) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = halt_req ? S_HALT : S_IF;
                    end
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB: begin
                retire    = 1'b1;
                state_nxt = halt_req ? S_HALT : S_IF;
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_nxt = S_IF;
                end
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase
    end

    // Moore stage enables and status flags.
    assign stage       = stage_onehot(state);
    assign IF          = stage[STG_IF];
    assign ID          = stage[STG_ID];
    assign EX          = stage[STG_EX];
    assign MEM         = stage[STG_MEM];
    assign WB          = stage[STG_WB];
    assign halted      = (state == S_HALT);
    assign timeout_err = (state == S_ERR);
    assign state_dbg   = state;

endmodule

// File: doc/dlx_ctrl_seq.md
# dlx_ctrl_seq

Parametrised multi-cycle control sequencer for the DLX core. It generates the one-hot IF/ID/EX/MEM/WB stage enables that drive the datapath. It adds what the fixed automaton lacks:
- wait states on the instruction-ROM and data-RAM valid handshakes
- a per-wait timeout with a sticky error state
- skipping of the MEM and WB stages per instruction class
- a halt request
- a retired-instruction counter

It sits between the decoder and the datapath/memory ports inside the DLX top.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.
- `TMO_W`, default 8: width of the wait-timeout counter.
- `TIMEOUT`, default 200: number of wait cycles before error. Legal range is 1 .. 2^TMO_W-1.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_data_valid`, in, 1: instruction ROM data valid.
- `d_data_valid`, in, 1: data RAM access complete.
- `is_mem`, in, 1: decoder flag, instruction accesses data RAM. Sampled in ID.
- `is_wb`, in, 1: decoder flag, instruction writes the register file. Sampled in ID.
- `halt_req`, in, 1: request to stop after the current instruction retires.
- `IF`, `ID`, `EX`, `MEM`, `WB`, out, 1 each: one-hot stage enables, all 0 in HALT and ERR.
- `retire`, out, 1: one-cycle pulse, instruction completed.
- `retire_cnt`, out, CNT_W: count of retired instructions.
- `halted`, out, 1: high in HALT.
- `timeout_err`, out, 1: high in ERR.

## Operation
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR. Outputs are Moore, decoded from state.
- While `reset` is high:
  - state = S_IF and `IF`=1.
  - All other outputs are 0, including `retire_cnt`=0.
  - Flags and the wait counter are cleared.
- S_IF: hold until `i_data_valid`=1, then go to S_ID.
- S_ID: one cycle. Latch `is_mem` into `mem_l` and `is_wb` into `wb_l`. Go to S_EX.
- S_EX: one cycle.
  - `mem_l`=1: go to S_MEM.
  - Else `wb_l`=1: go to S_WB.
  - Else retire.
- S_MEM: hold until `d_data_valid`=1.
  - Then `wb_l`=1: go to S_WB.
  - Else retire.
- S_WB: one cycle, then retire.
- Retire (the transition leaving EX, MEM or WB as described above):
  - `retire` pulses in the last cycle of the instruction.
  - `retire_cnt` increments at the following edge and wraps modulo 2^CNT_W.
  - Next state is S_HALT if `halt_req`=1 in that cycle, else S_IF.
- S_HALT: remain while `halt_req`=1. Return to S_IF in the cycle after `halt_req` falls.
- Timeout:
  - The wait counter clears on entry to S_IF or S_MEM and increments on each cycle spent waiting there without valid.
  - When the counter reaches TIMEOUT-1 and valid is still 0, go to S_ERR.
  - If valid arrives in that same cycle, valid wins and there is no error.
- S_ERR: sticky. Only `reset` exits.
- Valid inputs are ignored in every state other than the one waiting on them.
- Asserting `reset` mid-instruction aborts it:
  - No `retire` pulse.
  - Counter cleared.

## Timing
- Latency from S_IF entry to `retire`, with valid on the first cycle:
  - ALU op (wb, no mem): 4 cycles (IF, ID, EX, WB).
  - Load: 5 cycles.
  - Store: 4 cycles (IF, ID, EX, MEM).
  - Branch/nop: 3 cycles.
- Each wait cycle on a valid adds exactly 1 cycle.
- Back-to-back instructions: S_IF follows the retire cycle immediately, with no bubble.
- The maximum wait before error is TIMEOUT cycles in the wait state. `timeout_err` rises on the next edge.

## Structure
- Shared `dlx_pkg` holds:
  - `dlx_state_t`, an enum of the seven states.
  - Stage-index constants reused by the datapath.
- One sub-module, `dlx_wait_timer`, parameterised by TMO_W and TIMEOUT.
  - Inputs: `clr`, `run`.
  - Output: `expired`.
- The sequencer instantiates one `dlx_wait_timer`, shared by S_IF and S_MEM.

## Test plan
- Reset, then hold valids high. Issue ALU (`is_wb`=1), load, store, branch. Expect retire pulses at cycles 4, 9, 13, 16 and `retire_cnt`=4.
- Load with `d_data_valid` delayed 3 cycles: MEM is held 4 cycles, then WB, and retire occurs at cycle 8.
- With TIMEOUT=5:
  - Hold `i_data_valid`=0: S_ERR and `timeout_err`=1 after 5 IF cycles. The state stays there until reset.
  - Valid at the 5th wait cycle: no error.
- Assert `halt_req` during EX of a branch: retire, then S_HALT with `halted`=1 and all stage enables 0. Drop `halt_req`: `IF`=1 one cycle later.
- CNT_W=4: retire 17 instructions, expect `retire_cnt`=1.
- Assert `reset` during S_MEM: all outputs are cleared asynchronously, and after release `IF`=1 with `retire_cnt`=0.
